// File: rtl/rv32_pkg.sv
// Shared RV32I fetch types: widths, fetch FSM states, buffer entry layout
// and the instruction-address legality check.
package rv32_pkg;

  localparam int XLEN       = 32;
  localparam int ILEN_BYTES = 4;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // A fetch address is usable only if word aligned and inside the memory.
  function automatic logic addr_legal(input logic [XLEN-1:0] addr,
                                      input logic [XLEN-1:0] words);
    return (addr[1:0] == 2'b00) && ((addr >> 2) < words);
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of instruction-memory, decode handshake, redirect and status
// signals for the fetch controller. master = fetch side, slave = core side.
interface fetch_ctrl_if;
  import rv32_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            fault_valid;
  logic [XLEN-1:0] fault_pc;
  logic [XLEN-1:0] fetch_count;

  modport master (
    output imem_addr, if_valid, if_instr, if_pc, fault_valid, fault_pc, fetch_count,
    input  imem_rdata, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_addr, if_valid, if_instr, if_pc, fault_valid, fault_pc, fetch_count,
    output imem_rdata, redirect_valid, redirect_pc, if_ready
  );

endinterface

// File: rtl/fetch_buf.sv
// Two-entry shifting FIFO of fetch entries. Entry 0 is always the head, so
// the head output comes straight from a register.
module fetch_buf
  import rv32_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  fetch_entry_t entry0_r;
  fetch_entry_t entry1_r;
  logic [1:0]   count_r;
  logic         do_pop_s;
  logic         do_push_s;

  assign full      = (count_r == 2'd2);
  assign empty     = (count_r == 2'd0);
  assign head      = entry0_r;
  // Pop only real data; a push into a full buffer is allowed only alongside a pop.
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Entry storage and occupancy; flush discards everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0_r <= '0;
      entry1_r <= '0;
      count_r  <= 2'd0;
    end else if (flush) begin
      count_r  <= 2'd0;
    end else begin
      case ({do_push_s, do_pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            entry0_r <= din;
          end else begin
            entry1_r <= din;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          entry0_r <= entry1_r;
          count_r  <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd2) begin
            entry0_r <= entry1_r;
            entry1_r <= din;
          end else begin
            entry0_r <= din;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// RV32I instruction-fetch controller: owns the fetch PC, buffers returned
// words for decode, follows redirects and halts with a fault on illegal
// fetch targets.
module fetch_ctrl
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              MEM_WORDS = 45
)(
  input  logic          clk,
  input  logic          rst_n,
  fetch_ctrl_if.master  bus
);

  localparam logic [XLEN-1:0] MEM_WORDS_W = XLEN'(MEM_WORDS);
  localparam logic [XLEN-1:0] PC_STEP     = XLEN'(ILEN_BYTES);

  fetch_state_e    state_r, state_nxt_s;
  logic [XLEN-1:0] fetch_pc_r, fetch_pc_nxt_s;
  logic            fault_valid_r, fault_valid_nxt_s;
  logic [XLEN-1:0] fault_pc_r, fault_pc_nxt_s;
  logic [XLEN-1:0] fetch_count_r;

  logic            push_s;
  logic            pop_s;
  logic            flush_s;
  logic            slot_free_s;
  logic            buf_full_s;
  logic            buf_empty_s;
  fetch_entry_t    buf_din_s;
  fetch_entry_t    buf_head_s;

  assign pop_s       = !buf_empty_s && bus.if_ready;
  assign slot_free_s = !buf_full_s || pop_s;
  assign buf_din_s   = '{pc: fetch_pc_r, instr: bus.imem_rdata};

  fetch_buf u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .flush (flush_s),
    .din   (buf_din_s),
    .head  (buf_head_s),
    .full  (buf_full_s),
    .empty (buf_empty_s)
  );

  // Next-state logic: redirect wins, otherwise fetch sequentially while legal.
  always_comb begin
    state_nxt_s       = state_r;
    fetch_pc_nxt_s    = fetch_pc_r;
    fault_valid_nxt_s = fault_valid_r;
    fault_pc_nxt_s    = fault_pc_r;
    push_s            = 1'b0;
    flush_s           = 1'b0;
    if (bus.redirect_valid) begin
      flush_s = 1'b1;
      if (addr_legal(bus.redirect_pc, MEM_WORDS_W)) begin
        fetch_pc_nxt_s    = bus.redirect_pc;
        state_nxt_s       = RUN;
        fault_valid_nxt_s = 1'b0;
      end else begin
        state_nxt_s       = HALT;
        fault_valid_nxt_s = 1'b1;
        fault_pc_nxt_s    = bus.redirect_pc;
      end
    end else begin
      case (state_r)
        RUN: begin
          if (slot_free_s) begin
            if (addr_legal(fetch_pc_r, MEM_WORDS_W)) begin
              push_s         = 1'b1;
              fetch_pc_nxt_s = fetch_pc_r + PC_STEP;
            end else begin
              // Sequential overrun: stop here, buffered entries still drain.
              state_nxt_s       = HALT;
              fault_valid_nxt_s = 1'b1;
              fault_pc_nxt_s    = fetch_pc_r;
            end
          end else begin
            push_s = 1'b0;
          end
        end
        HALT: begin
          push_s = 1'b0;
        end
        default: begin
          state_nxt_s = HALT;
        end
      endcase
    end
  end

  // State, PC, fault and delivered-instruction counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= RUN;
      fetch_pc_r    <= RESET_PC;
      fault_valid_r <= 1'b0;
      fault_pc_r    <= '0;
      fetch_count_r <= '0;
    end else begin
      state_r       <= state_nxt_s;
      fetch_pc_r    <= fetch_pc_nxt_s;
      fault_valid_r <= fault_valid_nxt_s;
      fault_pc_r    <= fault_pc_nxt_s;
      fetch_count_r <= fetch_count_r + (pop_s ? 32'd1 : 32'd0);
    end
  end

  assign bus.imem_addr   = fetch_pc_r;
  assign bus.if_valid    = !buf_empty_s;
  assign bus.if_instr    = buf_head_s.instr;
  assign bus.if_pc       = buf_head_s.pc;
  assign bus.fault_valid = fault_valid_r;
  assign bus.fault_pc    = fault_pc_r;
  assign bus.fetch_count = fetch_count_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus queues the PCs decode should
// receive; a negedge monitor pops and compares every accepted instruction.
module tb_fetch_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   passed = 0;
  logic [31:0] exp_q[$];

  fetch_ctrl_if bus ();

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .MEM_WORDS(45)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[17:2]};
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.if_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    rst_n = 1'b0;
    tick();
    check("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
    check("rst_imem_addr", bus.imem_addr, 32'h0);
    check("rst_fault_valid", {31'd0, bus.fault_valid}, 32'd0);
    check("rst_fetch_count", bus.fetch_count, 32'd0);
    rst_n = 1'b1;
  endtask

  // Monitor: every accepted instruction must match the next queued PC.
  always @(negedge clk) begin
    if (rst_n && bus.if_valid && bus.if_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_pop: got pc %h expected no instruction", bus.if_pc);
      end else begin
        logic [31:0] epc;
        epc = exp_q.pop_front();
        check("if_pc", bus.if_pc, epc);
        check("if_instr", bus.if_instr, mem_word(epc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.if_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    // Reset then stream 0,4,8
    do_reset();
    check("s1_valid_c0", {31'd0, bus.if_valid}, 32'd0);
    check("s1_if_pc_rst", bus.if_pc, 32'h0);
    check("s1_if_instr_rst", bus.if_instr, 32'h0);
    bus.if_ready = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    tick();
    check("s1_first_valid", {31'd0, bus.if_valid}, 32'd1);
    tick(); tick(); tick();
    bus.if_ready = 1'b0;
    check("s1_count", bus.fetch_count, 32'd3);
    check("s1_q_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure
    do_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    for (int i = 0; i < 5; i++) tick();
    check("s2_head_pc", bus.if_pc, 32'h0);
    check("s2_imem_held", bus.imem_addr, 32'h8);
    check("s2_count0", bus.fetch_count, 32'd0);
    bus.if_ready = 1'b1;
    tick(); tick(); tick();
    bus.if_ready = 1'b0;
    check("s2_count", bus.fetch_count, 32'd3);
    check("s2_q_empty", 32'(exp_q.size()), 32'd0);

    // Redirect to 0x20 while full and popping
    do_reset();
    tick(); tick(); tick();
    check("s3_full_addr", bus.imem_addr, 32'h8);
    bus.if_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h20;
    exp_q.push_back(32'h0); exp_q.push_back(32'h20); exp_q.push_back(32'h24);
    tick();
    bus.redirect_valid = 1'b0;
    check("s3_flush_valid", {31'd0, bus.if_valid}, 32'd0);
    check("s3_imem_target", bus.imem_addr, 32'h20);
    check("s3_count_pop", bus.fetch_count, 32'd1);
    tick();
    check("s3_target_valid", {31'd0, bus.if_valid}, 32'd1);
    check("s3_target_pc", bus.if_pc, 32'h20);
    tick(); tick();
    bus.if_ready = 1'b0;
    check("s3_count", bus.fetch_count, 32'd3);
    check("s3_q_empty", 32'(exp_q.size()), 32'd0);

    // Misaligned redirect, HALT, then legal redirect
    do_reset();
    bus.if_ready = 1'b1;
    exp_q.push_back(32'h0);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h22;
    tick();
    bus.redirect_valid = 1'b0;
    check("s4_fault_valid", {31'd0, bus.fault_valid}, 32'd1);
    check("s4_fault_pc", bus.fault_pc, 32'h22);
    check("s4_count", bus.fetch_count, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s4_halt_valid", {31'd0, bus.if_valid}, 32'd0);
      check("s4_halt_addr", bus.imem_addr, 32'h4);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h1000;
    tick();
    bus.redirect_valid = 1'b0;
    check("s4_fault_pc2", bus.fault_pc, 32'h1000);
    check("s4_fault_valid2", {31'd0, bus.fault_valid}, 32'd1);
    tick();
    check("s4_halt_valid2", {31'd0, bus.if_valid}, 32'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h8;
    exp_q.push_back(32'h8);
    tick();
    bus.redirect_valid = 1'b0;
    check("s4_fault_clear", {31'd0, bus.fault_valid}, 32'd0);
    check("s4_imem_8", bus.imem_addr, 32'h8);
    tick();
    check("s4_resume_pc", bus.if_pc, 32'h8);
    tick();
    bus.if_ready = 1'b0;
    check("s4_q_empty", 32'(exp_q.size()), 32'd0);

    // Sequential run into the end of memory
    do_reset();
    for (int i = 0; i < 45; i++) exp_q.push_back(32'(i * 4));
    bus.if_ready = 1'b1;
    begin
      int n;
      n = 0;
      while (n < 80 && !(bus.fault_valid && exp_q.size() == 0 && !bus.if_valid)) begin
        tick();
        n++;
      end
      if (n >= 80) begin
        total++;
        $display("FAIL s5_timeout: got %0d cycles expected drain and fault", n);
      end
    end
    bus.if_ready = 1'b0;
    check("s5_fault_valid", {31'd0, bus.fault_valid}, 32'd1);
    check("s5_fault_pc", bus.fault_pc, 32'hB4);
    check("s5_count", bus.fetch_count, 32'd45);
    check("s5_q_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-stream
    do_reset();
    bus.if_ready = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    tick(); tick(); tick();
    bus.if_ready = 1'b0;
    check("s6_count_pre", bus.fetch_count, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("s6_arst_valid", {31'd0, bus.if_valid}, 32'd0);
    check("s6_arst_pc", bus.if_pc, 32'h0);
    check("s6_arst_instr", bus.if_instr, 32'h0);
    check("s6_arst_count", bus.fetch_count, 32'd0);
    check("s6_arst_addr", bus.imem_addr, 32'h0);
    #1 rst_n = 1'b1;
    exp_q.push_back(32'h0);
    bus.if_ready = 1'b1;
    tick();
    check("s6_restart_valid", {31'd0, bus.if_valid}, 32'd1);
    check("s6_restart_pc", bus.if_pc, 32'h0);
    tick();
    bus.if_ready = 1'b0;
    check("s6_count", bus.fetch_count, 32'd1);
    check("s6_q_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
